// File: rtl/radiant_readout_sequencer.sv
// -----------------------------------------------------------------------------
// radiant_readout_sequencer
//
// Sequences one event per accepted trigger. It performs a header handshake
// (valid/ready, carrying a 32-bit event number) and then runs 1..4 LAB4D
// readout sequences (start pulse out, done pulse back). It tracks how many
// downstream event buffers are in use, and raises sticky protocol error flags.
//
// Ports
//   sys_clk_i       system clock, rising edge
//   sys_rst_n_i     asynchronous active-low reset (release synchronised here)
//   en_i            sequencer enable; low forces IDLE on the next cycle
//   trig_i          1-cycle trigger pulse
//   nseq_i[1:0]     readout sequences per event minus 1 (latched at trigger)
//   hdr_valid_o     header request valid
//   hdr_ready_i     header sink ready (transfer = valid & ready)
//   hdr_evnum_o     event number carried with the header
//   seq_start_o     1-cycle pulse: start one readout sequence
//   seq_done_i      1-cycle pulse: readout sequence complete
//   buf_free_i      1-cycle pulse: one event buffer released downstream
//   readout_done_o  1-cycle pulse: event fully read out
//   readout_full_o  all NBUF event buffers in use (registered)
//   busy_o          sequencer not idle
//   occupancy_o     event buffers in use
//   err_o[1:0]      sticky: [0] sequence timeout, [1] underflow / trig while busy
//   err_clr_i       clears err_o; wins over a same-cycle set
// -----------------------------------------------------------------------------
module radiant_readout_sequencer #(
  parameter int NBUF    = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        en_i,
  input  logic        trig_i,
  input  logic [1:0]  nseq_i,
  output logic        hdr_valid_o,
  input  logic        hdr_ready_i,
  output logic [31:0] hdr_evnum_o,
  output logic        seq_start_o,
  input  logic        seq_done_i,
  input  logic        buf_free_i,
  output logic        readout_done_o,
  output logic        readout_full_o,
  output logic        busy_o,
  output logic [3:0]  occupancy_o,
  output logic [1:0]  err_o,
  input  logic        err_clr_i
);

  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_HDR   = 3'd1;
  localparam logic [2:0]  S_START = 3'd2;
  localparam logic [2:0]  S_WAIT  = 3'd3;
  localparam logic [2:0]  S_DONE  = 3'd4;

  localparam logic [3:0]  NBUF_L   = 4'(NBUF);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic        rst_meta;
  logic        rst_n;
  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [1:0]  nseq_q;
  logic [1:0]  seq_cnt;
  logic [15:0] timer;
  logic [1:0]  err_set;
  logic        occ_inc;
  logic        occ_dec;

  // Reset asserts asynchronously everywhere; release reaches the logic only
  // after two clock edges so no flop sees a release close to the edge.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    err_set   = 2'b00;
    // An event that is abandoned by en_i low never reaches the buffer count.
    occ_inc   = (state == S_DONE) && en_i;
    occ_dec   = buf_free_i && (occupancy_o != 4'd0);

    if (buf_free_i && (occupancy_o == 4'd0)) err_set[1] = 1'b1;
    if (trig_i && (state != S_IDLE))         err_set[1] = 1'b1;
    if (trig_i && (state == S_IDLE) && readout_full_o) err_set[1] = 1'b1;

    if (!en_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (trig_i && !readout_full_o) state_nxt = S_HDR;
        S_HDR:   if (hdr_ready_i) state_nxt = S_START;
        S_START: state_nxt = S_WAIT;
        S_WAIT: begin
          if (seq_done_i) begin
            state_nxt = (seq_cnt == nseq_q) ? S_DONE : S_START;
          end else if (timer == TMO_LAST) begin
            err_set[0] = 1'b1;
            state_nxt  = S_DONE;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      busy_o         <= 1'b0;
      hdr_valid_o    <= 1'b0;
      hdr_evnum_o    <= 32'd0;
      seq_start_o    <= 1'b0;
      readout_done_o <= 1'b0;
      readout_full_o <= 1'b0;
      occupancy_o    <= 4'd0;
      err_o          <= 2'b00;
      nseq_q         <= 2'd0;
      seq_cnt        <= 2'd0;
      timer          <= 16'd0;
    end else begin
      state       <= state_nxt;
      busy_o      <= (state_nxt != S_IDLE);
      // Valid is decoded from the next state so it appears in the first HDR
      // cycle; the start pulse lags START by one cycle, giving the
      // done-to-start spacing of two cycles.
      hdr_valid_o    <= (state_nxt == S_HDR);
      seq_start_o    <= (state == S_START) && en_i;
      readout_done_o <= occ_inc;

      if (hdr_valid_o && hdr_ready_i) hdr_evnum_o <= hdr_evnum_o + 32'd1;

      if ((state == S_IDLE) && (state_nxt == S_HDR)) nseq_q <= nseq_i;

      if (state == S_START)     timer <= 16'd0;
      else if (state == S_WAIT) timer <= timer + 16'd1;

      if (state_nxt == S_IDLE) seq_cnt <= 2'd0;
      else if ((state == S_WAIT) && (state_nxt == S_START)) seq_cnt <= seq_cnt + 2'd1;

      // Simultaneous increment and release cancel out.
      if (occ_inc && !occ_dec) begin
        if (occupancy_o != NBUF_L) occupancy_o <= occupancy_o + 4'd1;
      end else if (!occ_inc && occ_dec) begin
        occupancy_o <= occupancy_o - 4'd1;
      end

      // Deliberately one cycle behind occupancy.
      readout_full_o <= (occupancy_o == NBUF_L);

      err_o <= err_clr_i ? 2'b00 : (err_o | err_set);
    end
  end

endmodule

// File: tb/tb_radiant_readout_sequencer.sv
module tb_radiant_readout_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        trig;
  logic [1:0]  nseq;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] hdr_evnum;
  logic        seq_start;
  logic        seq_done;
  logic        buf_free;
  logic        rdone;
  logic        full;
  logic        busy;
  logic [3:0]  occ;
  logic [1:0]  err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_evnum = 32'd0;

  always #5 clk = ~clk;

  radiant_readout_sequencer #(.NBUF(4), .TIMEOUT(16)) dut (
    .sys_clk_i      (clk),
    .sys_rst_n_i    (rst_n),
    .en_i           (en),
    .trig_i         (trig),
    .nseq_i         (nseq),
    .hdr_valid_o    (hdr_valid),
    .hdr_ready_i    (hdr_ready),
    .hdr_evnum_o    (hdr_evnum),
    .seq_start_o    (seq_start),
    .seq_done_i     (seq_done),
    .buf_free_i     (buf_free),
    .readout_done_o (rdone),
    .readout_full_o (full),
    .busy_o         (busy),
    .occupancy_o    (occ),
    .err_o          (err),
    .err_clr_i      (err_clr)
  );

  typedef struct packed {
    logic        trig;
    logic        done;
    logic        free;
    logic        hv;
    logic        ss;
    logic        rd;
    logic        busy;
    logic [3:0]  occ;
    logic [31:0] evn;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic t, input logic d, input logic f,
                              input logic hv, input logic ss, input logic rd,
                              input logic b, input logic [3:0] o, input logic [31:0] e);
    vec_t v;
    v.trig = t; v.done = d; v.free = f;
    v.hv = hv; v.ss = ss; v.rd = rd; v.busy = b; v.occ = o; v.evn = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs an already-triggered event to completion, answering every start
  // pulse with an immediate done pulse, and counts the pulses seen.
  task automatic finish_event(output int starts, output int dones);
    starts = 0;
    dones  = 0;
    for (int c = 0; c < 100 && dones == 0; c++) begin
      seq_done = 1'b0;
      if (seq_start) begin starts++; seq_done = 1'b1; end
      if (rdone) dones++;
      tick();
    end
    seq_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (seq_start) starts++;
      if (rdone) dones++;
      tick();
    end
  endtask

  task automatic do_event(input logic [1:0] n, output int starts, output int dones);
    nseq = n;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    exp_evnum++;
    finish_event(starts, dones);
  endtask

  task automatic free_one();
    buf_free = 1'b1;
    tick();
    buf_free = 1'b0;
  endtask

  int starts, dones, bad, err_cyc, done_cyc, seen;

  initial begin
    rst_n = 1'b0; en = 1'b0; trig = 1'b0; nseq = 2'd0; hdr_ready = 1'b0;
    seq_done = 1'b0; buf_free = 1'b0; err_clr = 1'b0;

    // Reset state
    repeat (3) tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset hdr_valid", 32'(hdr_valid), 32'd0);
    check("reset evnum", hdr_evnum, 32'd0);
    check("reset occ/full/err", {25'd0, occ, full, err}, 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    hdr_ready = 1'b1;
    repeat (4) tick();

    // Single-sequence event, cycle by cycle
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 0, 1, 4'd0, 32'd0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 4'd0, 32'd1);
    tbl[3]  = mk(0, 0, 0, 0, 1, 0, 1, 4'd0, 32'd1);
    for (int i = 4; i < 10; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 1, 4'd0, 32'd1);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 1, 4'd0, 32'd1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 4'd0, 32'd1);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, 4'd1, 32'd1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 4'd1, 32'd1);
    nseq = 2'd0;
    for (int i = 0; i < 14; i++) begin
      check($sformatf("t1 cycle %0d hv/ss/rd/busy/occ", i),
            {24'd0, hdr_valid, seq_start, rdone, busy, occ},
            {24'd0, tbl[i].hv, tbl[i].ss, tbl[i].rd, tbl[i].busy, tbl[i].occ});
      check($sformatf("t1 cycle %0d evnum", i), hdr_evnum, tbl[i].evn);
      trig = tbl[i].trig; seq_done = tbl[i].done; buf_free = tbl[i].free;
      tick();
    end
    trig = 1'b0; seq_done = 1'b0; buf_free = 1'b0;
    exp_evnum = 32'd1;

    // Four sequences in one event
    do_event(2'd3, starts, dones);
    check("t2 starts", starts, 32'd4);
    check("t2 dones", dones, 32'd1);
    check("t2 occ", 32'(occ), 32'd2);
    check("t2 evnum", hdr_evnum, exp_evnum);

    // Fill all buffers, then reject a trigger
    do_event(2'd0, starts, dones);
    do_event(2'd1, starts, dones);
    check("t3 occ full", 32'(occ), 32'd4);
    check("t3 full", 32'(full), 32'd1);
    check("t3 err before", 32'(err), 32'd0);
    trig = 1'b1; tick(); trig = 1'b0;
    check("t3 rejected hv", 32'(hdr_valid), 32'd0);
    check("t3 rejected busy", 32'(busy), 32'd0);
    check("t3 err[1]", 32'(err), 32'd2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t3 err clr", 32'(err), 32'd0);
    free_one();
    check("t3 occ after free", 32'(occ), 32'd3);
    check("t3 full lags", 32'(full), 32'd1);
    tick();
    check("t3 full cleared", 32'(full), 32'd0);
    do_event(2'd0, starts, dones);
    check("t3 accepted dones", dones, 32'd1);
    check("t3 occ back", 32'(occ), 32'd4);
    free_one();
    free_one();
    check("t3 occ 2", 32'(occ), 32'd2);

    // Header backpressure
    hdr_ready = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!hdr_valid || hdr_evnum !== exp_evnum || seq_start) bad++;
      tick();
    end
    check("t4 held cycles bad", bad, 32'd0);
    check("t4 still valid", 32'(hdr_valid), 32'd1);
    hdr_ready = 1'b1;
    tick();
    exp_evnum++;
    check("t4 valid dropped", 32'(hdr_valid), 32'd0);
    check("t4 evnum inc", hdr_evnum, exp_evnum);
    finish_event(starts, dones);
    check("t4 starts", starts, 32'd1);
    check("t4 occ", 32'(occ), 32'd3);

    // Sequence timeout
    nseq = 2'd0;
    trig = 1'b1; tick(); trig = 1'b0;
    exp_evnum++;
    err_cyc = -1; done_cyc = -1;
    for (int c = 1; c < 60 && done_cyc < 0; c++) begin
      if (err[0] && err_cyc < 0) err_cyc = c;
      if (rdone) done_cyc = c;
      tick();
    end
    check("t5 err cycle", err_cyc, 32'd19);
    check("t5 done cycle", done_cyc, 32'd20);
    check("t5 err value", 32'(err), 32'd1);
    check("t5 occ", 32'(occ), 32'd4);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t5 err clr", 32'(err), 32'd0);

    // DONE coincident with buf_free; clear beats a same-cycle set
    free_one();
    free_one();
    check("t6 occ 2", 32'(occ), 32'd2);
    trig = 1'b1; tick(); trig = 1'b0;
    exp_evnum++;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (seq_start) seen = 1; else tick();
    end
    check("t6 start seen", seen, 32'd1);
    seq_done = 1'b1; tick(); seq_done = 1'b0;
    buf_free = 1'b1; trig = 1'b1; err_clr = 1'b1;
    tick();
    buf_free = 1'b0; trig = 1'b0; err_clr = 1'b0;
    check("t6 rdone", 32'(rdone), 32'd1);
    check("t6 occ net", 32'(occ), 32'd2);
    check("t6 err clr wins", 32'(err), 32'd0);

    // en_i low mid-WAIT
    trig = 1'b1; tick(); trig = 1'b0;
    exp_evnum++;
    repeat (4) tick();
    check("t6 in wait busy", 32'(busy), 32'd1);
    en = 1'b0; tick();
    check("t6 abort busy", 32'(busy), 32'd0);
    en = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      seq_done = (i == 1);
      if (rdone || seq_start || busy) bad++;
      tick();
    end
    seq_done = 1'b0;
    check("t6 abort quiet", bad, 32'd0);
    check("t6 abort occ", 32'(occ), 32'd2);
    check("t6 abort evnum", hdr_evnum, exp_evnum);

    // Underflow
    free_one();
    free_one();
    check("t6 occ 0", 32'(occ), 32'd0);
    check("t6 no err yet", 32'(err), 32'd0);
    free_one();
    check("t6 underflow occ", 32'(occ), 32'd0);
    check("t6 underflow err", 32'(err), 32'd2);

    // Asynchronous reset mid-event
    trig = 1'b1; tick(); trig = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst evnum", hdr_evnum, 32'd0);
    check("arst err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    exp_evnum = 32'd0;
    do_event(2'd0, starts, dones);
    check("arst recovery dones", dones, 32'd1);
    check("arst recovery evnum", hdr_evnum, exp_evnum);
    check("arst recovery occ", 32'(occ), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
